// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: pixel-rate divider, h/v position counters,
// active-low syncs, visible-area flag and frame-start strobe, all registered.
module vga_timing_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       pix_en,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       hsync,
  output logic       vsync,
  output logic       bright,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  // Divider holds 0..15, enough for the full 1..16 CLK_DIV range.
  localparam logic [4:0] DIV_LAST   = 5'(CLK_DIV - 1);

  logic [4:0] div_r;
  logic       pix_en_r;
  logic [9:0] hcount_r;
  logic [9:0] vcount_r;
  logic       hsync_r;
  logic       vsync_r;
  logic       bright_r;
  logic       frame_start_r;

  logic [9:0] h_next_s;
  logic [9:0] v_next_s;
  logic       hsync_next_s;
  logic       vsync_next_s;
  logic       bright_next_s;
  logic       frame_start_next_s;

  // Pixel-rate divider and its registered one-clk tick.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_r    <= 5'd0;
      pix_en_r <= 1'b0;
    end else begin
      pix_en_r <= (div_r == DIV_LAST);
      if (div_r == DIV_LAST) begin
        div_r <= 5'd0;
      end else begin
        div_r <= div_r + 5'd1;
      end
    end
  end

  // Next raster position, advancing only on a pixel tick.
  always_comb begin
    h_next_s = hcount_r;
    v_next_s = vcount_r;
    if (pix_en_r) begin
      if (hcount_r == H_LAST) begin
        h_next_s = 10'd0;
        if (vcount_r == V_LAST) begin
          v_next_s = 10'd0;
        end else begin
          v_next_s = vcount_r + 10'd1;
        end
      end else begin
        h_next_s = hcount_r + 10'd1;
        v_next_s = vcount_r;
      end
    end else begin
      h_next_s = hcount_r;
      v_next_s = vcount_r;
    end
  end

  // Decode from the next position so the flags line up with the counters they describe.
  always_comb begin
    hsync_next_s       = !((h_next_s >= HS_START) && (h_next_s < HS_END));
    vsync_next_s       = !((v_next_s >= VS_START) && (v_next_s < VS_END));
    bright_next_s      = (h_next_s < H_VIS_END) && (v_next_s < V_VIS_END);
    frame_start_next_s = pix_en_r && (h_next_s == 10'd0) && (v_next_s == 10'd0);
  end

  // Position and decoded output registers; reset parks at the last position of a frame.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hcount_r      <= H_LAST;
      vcount_r      <= V_LAST;
      hsync_r       <= 1'b1;
      vsync_r       <= 1'b1;
      bright_r      <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      hcount_r      <= h_next_s;
      vcount_r      <= v_next_s;
      hsync_r       <= hsync_next_s;
      vsync_r       <= vsync_next_s;
      bright_r      <= bright_next_s;
      frame_start_r <= frame_start_next_s;
    end
  end

  assign pix_en      = pix_en_r;
  assign hcount      = hcount_r;
  assign vcount      = vcount_r;
  assign hsync       = hsync_r;
  assign vsync       = vsync_r;
  assign bright      = bright_r;
  assign frame_start = frame_start_r;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates the 640x480 @ 60 Hz VGA raster timing that drives the game display. It divides the system clock down to a pixel-rate enable and runs horizontal and vertical position counters. It produces active-low sync pulses, a visible-area flag and a frame-start strobe. Its hcount/vcount/bright outputs are the coordinates the pixel-colour block consumes to select each pixel's colour.

## Interface
- CLK_DIV, 4: system clocks per pixel (100 MHz -> 25 MHz); legal range 1..16
- H_VISIBLE, 640: visible pixels per line
- H_FRONT, 16: horizontal front porch, pixels
- H_SYNC, 96: hsync pulse width, pixels
- H_BACK, 48: horizontal back porch, pixels
- V_VISIBLE, 480: visible lines per frame
- V_FRONT, 10: vertical front porch, lines
- V_SYNC, 2: vsync pulse width, lines
- V_BACK, 33: vertical back porch, lines

Ports:
- clk  in  1  system clock; the only clock
- reset_n  in  1  reset, synchronous, active-low
- pix_en  out  1  one-clk pixel tick, asserted once every CLK_DIV clks
- hcount  out  10  horizontal position, 0..H_TOTAL-1
- vcount  out  10  vertical position, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- bright  out  1  high while (hcount, vcount) is inside the visible area
- frame_start  out  1  one-clk pulse when the position becomes (0,0)

## Operation
- Totals: H_TOTAL = sum of the four H parameters = 800; V_TOTAL = sum of the four V parameters = 525.
- Divider: a counter runs 0..CLK_DIV-1 and wraps. pix_en is registered and high for exactly one clk when the divider is at CLK_DIV-1. With CLK_DIV=1, pix_en is constantly high after reset.
- Position update happens only on a clk edge where pix_en is high:
  - hcount increments.
  - At H_TOTAL-1, hcount wraps to 0 and vcount increments.
  - At (H_TOTAL-1, V_TOTAL-1), both wrap to 0.
- hsync = 0 exactly when H_VISIBLE+H_FRONT <= hcount < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751.
- vsync = 0 exactly when V_VISIBLE+V_FRONT <= vcount < V_VISIBLE+V_FRONT+V_SYNC, i.e. 490..491.
- bright = 1 exactly when hcount < H_VISIBLE and vcount < V_VISIBLE.
- All outputs are registered. hsync, vsync and bright are decoded from the next counter values, so they always describe the hcount/vcount currently presented. They never lag by a cycle.
- Counter widths: all counter and decode comparisons are unsigned, 10 bits. Counters never exceed TOTAL-1 and there is no overflow path.

## Timing
- Reset (reset_n = 0 at a clk edge) forces, on that edge:
  - divider = 0, pix_en = 0, frame_start = 0
  - hcount = H_TOTAL-1 (799), vcount = V_TOTAL-1 (524)
  - hsync = 1, vsync = 1, bright = 0
  - These values are mutually consistent, so there is no glitch at release.
- Reset applies mid-frame with identical effect at any position. Reset has priority over pix_en on the same edge.
- After release, the first pix_en is high during the CLK_DIV-th clk cycle.
- The edge after that first pix_en loads (0,0), sets bright = 1, and drives frame_start = 1 for exactly one clk. So the first frame begins CLK_DIV+1 clks after release.
- Outputs hold steady for CLK_DIV clks between pix_en-qualified edges.
- frame_start is high for one clk per frame, regardless of CLK_DIV.
- Frame period is H_TOTAL*V_TOTAL*CLK_DIV clks = 1,680,000 at the defaults.

## Test plan
- Reset release: hold reset_n = 0 for 3 clks, then release.
  - Required during reset: hcount = 799, vcount = 524, hsync = vsync = 1, bright = 0.
  - Required after release: pix_en pulses 1 clk wide every 4 clks; (0,0) and frame_start appear on the 5th clk after release.
- Line timing:
  - hsync falls on the edge loading hcount = 656 and rises on the edge loading 752, i.e. 384 clks low.
  - bright falls on the edge loading hcount = 640.
  - 800 pix_en ticks per line.
- Line/frame wrap:
  - hcount 799 -> 0 increments vcount, e.g. 100 -> 101.
  - At (799, 524) the next tick yields (0,0) with a one-clk frame_start.
  - vsync is low only for vcount 490..491, i.e. 2 lines = 6400 clks.
- Frame census over one full frame:
  - 307,200 ticks with bright = 1.
  - Exactly one frame_start pulse.
  - Frame period 1,680,000 clks.
- Mid-operation reset: assert reset_n = 0 for one clk at (300, 100) -> the next edge shows reset values, and timing restarts as in the reset-release scenario.
- CLK_DIV = 1 build: pix_en stays high after release, hcount increments every clk, and the frame period is 420,000 clks.
